// File: rtl/ddr_wr_arb.sv
// Two-requester round-robin arbiter in front of a single DDR write datamover.
// One transaction in flight: command, data burst, then response routed back.
module ddr_wr_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              req_wreq_valid,
    output logic [1:0]              req_wreq_ready,
    input  logic [2*ADDR_WIDTH-1:0] req_wreq_addr,
    input  logic [2*SIZE_WIDTH-1:0] req_wreq_size,
    input  logic [1:0]              req_wdata_valid,
    output logic [1:0]              req_wdata_ready,
    input  logic [1:0]              req_wdata_last,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_wresp_valid,
    output logic [1:0]              req_wresp,
    input  logic                    ddr_wreq_ready,
    output logic                    ddr_wreq_valid,
    output logic [ADDR_WIDTH-1:0]   ddr_wreq_addr,
    output logic [SIZE_WIDTH-1:0]   ddr_wreq_size,
    input  logic                    ddr_wdata_ready,
    output logic                    ddr_wdata_valid,
    output logic                    ddr_wdata_last,
    output logic [DATA_WIDTH-1:0]   ddr_wdata,
    input  logic                    ddr_wresp_valid,
    input  logic [1:0]              ddr_wresp,
    output logic                    grant_id,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       grant;
    logic       grant_nxt;
    logic       last_grant;
    logic       last_grant_nxt;
    logic       pick;
    logic       resp_fire;
    logic [1:0] gmask;
    logic [1:0] wresp_valid_q;
    logic [1:0] wresp_q;

    assign gmask = {grant, ~grant};

    // On a tie the requester not served last wins; otherwise the lone one.
    assign pick = (&req_wreq_valid) ? ~last_grant : req_wreq_valid[1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            wresp_valid_q <= 2'b00;
            wresp_q       <= 2'b00;
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            last_grant    <= last_grant_nxt;
            wresp_valid_q <= resp_fire ? gmask : 2'b00;
            if (resp_fire) begin
                wresp_q <= ddr_wresp;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        last_grant_nxt  = last_grant;
        resp_fire       = 1'b0;
        ddr_wreq_valid  = 1'b0;
        ddr_wdata_valid = 1'b0;
        req_wreq_ready  = 2'b00;
        req_wdata_ready = 2'b00;
        unique case (state)
            IDLE: begin
                if (|req_wreq_valid) begin
                    grant_nxt = pick;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                ddr_wreq_valid = 1'b1;
                req_wreq_ready = ddr_wreq_ready ? gmask : 2'b00;
                if (ddr_wreq_ready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                ddr_wdata_valid = req_wdata_valid[grant];
                req_wdata_ready = ddr_wdata_ready ? gmask : 2'b00;
                if (req_wdata_valid[grant] && ddr_wdata_ready &&
                    req_wdata_last[grant]) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (ddr_wresp_valid) begin
                    resp_fire      = 1'b1;
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ddr_wreq_addr  = grant ? req_wreq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : req_wreq_addr[ADDR_WIDTH-1:0];
    assign ddr_wreq_size  = grant ? req_wreq_size[2*SIZE_WIDTH-1:SIZE_WIDTH]
                                  : req_wreq_size[SIZE_WIDTH-1:0];
    assign ddr_wdata      = grant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_wdata[DATA_WIDTH-1:0];
    assign ddr_wdata_last = req_wdata_last[grant];

    assign req_wresp_valid = wresp_valid_q;
    assign req_wresp       = wresp_q;
    assign grant_id        = grant;
    assign busy            = (state != IDLE);

endmodule
